// File: rtl/eeg_filter_pkg.sv
// Shared constants for the EEG filter chain and its alpha-band power detector.
package eeg_filter_pkg;
    localparam int EEG_DATA_W     = 32;
    localparam int ALPHA_WIN_LOG2 = 8;
    localparam logic [2*EEG_DATA_W-1:0] ALPHA_THRESH_DEFAULT = 64'd1_000_000;
endpackage

// File: rtl/sq_accum.sv
// Squaring stage plus block accumulator over 2**WIN_LOG2 samples.
// Raises res_strobe in the cycle the window's last square is being added.
module sq_accum
    import eeg_filter_pkg::*;
#(
    parameter int DATA_W   = EEG_DATA_W,
    parameter int WIN_LOG2 = ALPHA_WIN_LOG2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     sample_en,
    input  logic signed [DATA_W-1:0] x,
    output logic                     res_strobe,
    output logic [2*DATA_W-1:0]      res_mean
);
    localparam int PW = 2 * DATA_W;
    localparam int AW = PW + WIN_LOG2;

    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [PW-1:0]       sq_q, sq_d;
    logic                sq_v_q, sq_v_d;
    logic                last_q, last_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [AW-1:0]       sum;
    logic signed [PW-1:0] prod;

    // Signed product is never negative and tops out at 2**(PW-2), so it is safe as unsigned.
    assign prod = x * x;

    always_comb begin
        cnt_d  = cnt_q;
        sq_d   = sq_q;
        sq_v_d = 1'b0;
        last_d = last_q;
        acc_d  = acc_q;
        sum    = acc_q + AW'(sq_q);

        if (clear) begin
            cnt_d = '0;
            acc_d = '0;
        end else begin
            if (sample_en) begin
                sq_d   = prod;
                sq_v_d = 1'b1;
                last_d = &cnt_q;
                cnt_d  = cnt_q + 1'b1;
            end
            if (sq_v_q) begin
                acc_d = last_q ? '0 : sum;
            end
        end
    end

    assign res_strobe = sq_v_q & last_q & ~clear;
    assign res_mean   = sum[WIN_LOG2 +: PW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            sq_q   <= '0;
            sq_v_q <= 1'b0;
            last_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sq_q   <= sq_d;
            sq_v_q <= sq_v_d;
            last_q <= last_d;
            acc_q  <= acc_d;
        end
    end
endmodule

// File: rtl/alpha_power_detect.sv
// Alpha-band mean power over a block window, with threshold detect,
// valid/ready result handshake and a sticky overrun flag.
module alpha_power_detect
    import eeg_filter_pkg::*;
#(
    parameter int DATA_W   = EEG_DATA_W,
    parameter int WIN_LOG2 = ALPHA_WIN_LOG2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     sample_en,
    input  logic signed [DATA_W-1:0] x,
    input  logic [2*DATA_W-1:0]      thresh,
    output logic [2*DATA_W-1:0]      power,
    output logic                     power_valid,
    input  logic                     power_ready,
    output logic                     detect,
    output logic                     overrun
);
    logic                res_strobe;
    logic [2*DATA_W-1:0] res_mean;

    logic [2*DATA_W-1:0] power_q, power_d;
    logic                valid_q, valid_d;
    logic                detect_q, detect_d;
    logic                overrun_q, overrun_d;

    sq_accum #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_sq_accum (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .sample_en  (sample_en),
        .x          (x),
        .res_strobe (res_strobe),
        .res_mean   (res_mean)
    );

    always_comb begin
        power_d   = power_q;
        valid_d   = valid_q;
        detect_d  = detect_q;
        overrun_d = overrun_q;

        if (valid_q && power_ready) begin
            valid_d = 1'b0;
        end
        // A fresh result always wins over an acknowledge on the same edge.
        if (res_strobe) begin
            power_d  = res_mean;
            detect_d = (res_mean > thresh);
            valid_d  = 1'b1;
            if (valid_q && !power_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            power_q   <= '0;
            valid_q   <= 1'b0;
            detect_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            power_q   <= power_d;
            valid_q   <= valid_d;
            detect_q  <= detect_d;
            overrun_q <= overrun_d;
        end
    end

    assign power       = power_q;
    assign power_valid = valid_q;
    assign detect      = detect_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_alpha_power_detect.sv
// Directed bench for alpha_power_detect with a 4-sample window.
module tb_alpha_power_detect;
    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 clear = 1'b0;
    logic                 sample_en = 1'b0;
    logic signed [DW-1:0] x = '0;
    logic [2*DW-1:0]      thresh = '0;
    logic [2*DW-1:0]      power;
    logic                 power_valid;
    logic                 power_ready = 1'b0;
    logic                 detect;
    logic                 overrun;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string           name;
        logic [3:0][31:0] xs;
        logic [63:0]     thr;
        logic [63:0]     exp_power;
        logic            exp_detect;
    } vec_t;

    vec_t vecs [7];

    alpha_power_detect #(.DATA_W(DW), .WIN_LOG2(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .sample_en   (sample_en),
        .x           (x),
        .thresh      (thresh),
        .power       (power),
        .power_valid (power_valid),
        .power_ready (power_ready),
        .detect      (detect),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] v);
        sample_en = 1'b1;
        x = v;
        step();
        sample_en = 1'b0;
    endtask

    task automatic set_vec(input int i, input string n, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input logic [63:0] t,
                           input logic [63:0] p, input logic det);
        vecs[i].name       = n;
        vecs[i].xs[0]      = a;
        vecs[i].xs[1]      = b;
        vecs[i].xs[2]      = c;
        vecs[i].xs[3]      = d;
        vecs[i].thr        = t;
        vecs[i].exp_power  = p;
        vecs[i].exp_detect = det;
    endtask

    initial begin
        set_vec(0, "alt3_thr8",  32'd3, -32'sd3, 32'd3, -32'sd3, 64'd8, 64'd9, 1'b1);
        set_vec(1, "alt3_thr9",  32'd3, -32'sd3, 32'd3, -32'sd3, 64'd9, 64'd9, 1'b0);
        set_vec(2, "min_neg",    32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                64'd0, 64'h4000_0000_0000_0000, 1'b1);
        set_vec(3, "zeros",      32'd0, 32'd0, 32'd0, 32'd0, 64'd0, 64'd0, 1'b0);
        set_vec(4, "ramp_eq",    32'd1, 32'd2, 32'd3, 32'd4, 64'd7, 64'd7, 1'b0);
        set_vec(5, "mix_above",  32'd5, -32'sd5, 32'd1, 32'd1, 64'd12, 64'd13, 1'b1);
        set_vec(6, "max_pos",    32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0);

        // Asynchronous reset assertion between edges, checked before any clock edge.
        #2 reset = 1'b0;
        #2;
        chk("rst_power", power, 64'd0);
        chk("rst_valid", 64'(power_valid), 64'd0);
        chk("rst_detect", 64'(detect), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        foreach (vecs[i]) begin
            thresh = vecs[i].thr;
            for (int k = 0; k < 4; k++) feed(vecs[i].xs[k]);
            chk({vecs[i].name, "_valid_early"}, 64'(power_valid), 64'd0);
            step();
            chk({vecs[i].name, "_valid"}, 64'(power_valid), 64'd1);
            chk({vecs[i].name, "_power"}, power, vecs[i].exp_power);
            chk({vecs[i].name, "_detect"}, 64'(detect), 64'(vecs[i].exp_detect));
            chk({vecs[i].name, "_overrun"}, 64'(overrun), 64'd0);
            power_ready = 1'b1;
            step();
            power_ready = 1'b0;
            chk({vecs[i].name, "_ack"}, 64'(power_valid), 64'd0);
            $display("vector %s: power=0x%0h detect=%0b", vecs[i].name, power, detect);
        end

        // Clear mid-window, and a sample_en coinciding with clear is dropped.
        thresh = 64'd3;
        feed(32'd100);
        feed(32'd100);
        clear = 1'b1;
        feed(32'd100);
        clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            feed(32'd2);
            chk("clr_no_early_result", 64'(power_valid), 64'd0);
        end
        step();
        chk("clr_valid", 64'(power_valid), 64'd1);
        chk("clr_power", power, 64'd4);
        chk("clr_detect", 64'(detect), 64'd1);
        power_ready = 1'b1;
        step();
        power_ready = 1'b0;
        $display("clear sequence: power=0x%0h", power);

        // Two windows with no acknowledge: second result overwrites and flags overrun.
        thresh = 64'd0;
        for (int k = 0; k < 4; k++) feed(32'd1);
        for (int k = 0; k < 4; k++) feed(32'd2);
        step();
        chk("ovr_power", power, 64'd4);
        chk("ovr_valid", 64'(power_valid), 64'd1);
        chk("ovr_flag", 64'(overrun), 64'd1);
        power_ready = 1'b1;
        step();
        power_ready = 1'b0;
        chk("ovr_ack", 64'(power_valid), 64'd0);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        $display("overrun sequence: power=0x%0h overrun=%0b", power, overrun);

        // Async reset with a pending result and a partial window in flight.
        for (int k = 0; k < 4; k++) feed(32'd3);
        step();
        chk("pre_rst_valid", 64'(power_valid), 64'd1);
        feed(32'd7);
        feed(32'd7);
        #3 reset = 1'b0;
        #1;
        chk("arst_power", power, 64'd0);
        chk("arst_valid", 64'(power_valid), 64'd0);
        chk("arst_detect", 64'(detect), 64'd0);
        chk("arst_overrun", 64'(overrun), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        for (int k = 0; k < 4; k++) feed(32'd1);
        step();
        chk("post_rst_valid", 64'(power_valid), 64'd1);
        chk("post_rst_power", power, 64'd1);
        chk("post_rst_detect", 64'(detect), 64'd1);
        $display("reset sequence: power=0x%0h", power);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
